// File: rtl/knock_pkg.sv
// Shared types and defaults for the router link blocks (flit transmitter, credit counter).
package knock_pkg;
  localparam int FLIT_W      = 16;
  localparam int DEF_CREDITS = 5;
  localparam int CREDIT_W    = $clog2(DEF_CREDITS + 1);

  typedef logic [CREDIT_W-1:0] credit_t;
  typedef logic [FLIT_W-1:0]   flit_t;
endpackage

// File: rtl/flit_link_tx_credit_counter.sv
// Up/down saturating credit counter with a sticky overflow flag.
// Starts full (MAX) and is shared by the link transmitter and receiver side.
module credit_counter
  import knock_pkg::*;
#(
  parameter int MAX = DEF_CREDITS,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         err
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q, count_d;
  logic         err_q, err_d;

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (inc && !dec) begin
      // A return with no slot outstanding is a protocol error; hold at MAX.
      if (count_q == MAX_V) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= MAX_V;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: rtl/flit_link_tx.sv
// Drains a first-word-fall-through FIFO onto a credit-gated point-to-point link,
// one flit per cycle, with a registered launch stage and a launched-flit counter.
module flit_link_tx
  import knock_pkg::*;
#(
  parameter int WIDTH   = FLIT_W,
  parameter int CREDITS = DEF_CREDITS,
  parameter int CNT_W   = $clog2(CREDITS + 1),
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  fifo_data,
  output logic              fifo_pop_n,
  output logic              link_valid,
  output logic [WIDTH-1:0]  link_data,
  input  logic              credit_return,
  output logic [CNT_W-1:0]  credits_avail,
  output logic              credit_err,
  output logic [STAT_W-1:0] flit_count
);

  // Handshake: the FIFO head is consumed on the edge where fifo_pop_n=0; the
  // link has no ready, so link_valid=1 means the flit is delivered that cycle.
  logic fire;

  logic              link_valid_q, link_valid_d;
  logic [WIDTH-1:0]  link_data_q, link_data_d;
  logic [STAT_W-1:0] flit_count_q, flit_count_d;

  // rst gates the combinational pop so the FIFO is never drained during reset.
  assign fire       = ~rst & en & ~fifo_empty & (credits_avail != '0);
  assign fifo_pop_n = ~fire;

  credit_counter #(
    .MAX (CREDITS),
    .W   (CNT_W)
  ) u_credit_counter (
    .clk   (clk),
    .rst   (rst),
    .dec   (fire),
    .inc   (credit_return),
    .count (credits_avail),
    .err   (credit_err)
  );

  always_comb begin
    link_valid_d = fire;
    link_data_d  = link_data_q;
    flit_count_d = flit_count_q;
    if (fire) begin
      link_data_d  = fifo_data;
      flit_count_d = flit_count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      flit_count_q <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_data_q  <= link_data_d;
      flit_count_q <= flit_count_d;
    end
  end

  assign link_valid = link_valid_q;
  assign link_data  = link_data_q;
  assign flit_count = flit_count_q;

endmodule

// File: tb/tb_flit_link_tx.sv
// Directed bench for flit_link_tx with a small FWFT FIFO model on the read side.
module tb_flit_link_tx;

  logic        clk;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        fifo_pop_n;
  logic        link_valid;
  logic [15:0] link_data;
  logic        credit_return;
  logic [2:0]  credits_avail;
  logic        credit_err;
  logic [15:0] flit_count;

  int checks;
  int failures;

  logic [15:0] mem [16];
  logic [3:0]  rd_ptr;
  logic [3:0]  wr_ptr;

  flit_link_tx dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_pop_n    (fifo_pop_n),
    .link_valid    (link_valid),
    .link_data     (link_data),
    .credit_return (credit_return),
    .credits_avail (credits_avail),
    .credit_err    (credit_err),
    .flit_count    (flit_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr];

  always @(posedge clk) begin
    if (!fifo_pop_n) begin
      if (fifo_empty) begin
        failures = failures + 1;
        $display("FAIL empty_pop: pop_n=%0b while fifo_empty=%0b, required no pop", fifo_pop_n, fifo_empty);
      end
      rd_ptr <= rd_ptr + 4'd1;
    end
  end

  // driver tasks
  task automatic push(input logic [15:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 4'd1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    en            = 1'b1;
    credit_return = 1'b0;
    @(negedge clk);
    wr_ptr = rd_ptr;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    checks = checks + 1;
    if ({link_valid, link_data, credits_avail, credit_err, flit_count, fifo_pop_n} !==
        {1'b0, 16'h0000, 3'd5, 1'b0, 16'h0000, 1'b1}) begin
      failures = failures + 1;
      $display("FAIL reset_state: valid=%0b data=%h cred=%0d err=%0b cnt=%0d pop_n=%0b, required 0 0000 5 0 0 1",
               link_valid, link_data, credits_avail, credit_err, flit_count, fifo_pop_n);
    end
  endtask

  task automatic test_burst();
    do_reset();
    for (int i = 1; i <= 6; i++) push(16'(i));
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks = checks + 1;
      if (link_valid !== 1'b1 || link_data !== 16'(i) || credits_avail !== 3'(5 - i)) begin
        failures = failures + 1;
        $display("FAIL burst_%0d: valid=%0b data=%h cred=%0d, required 1 %h %0d",
                 i, link_valid, link_data, credits_avail, 16'(i), 5 - i);
      end
    end
    checks = checks + 1;
    if (fifo_pop_n !== 1'b1 || fifo_empty !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL burst_starved: pop_n=%0b empty=%0b, required 1 0", fifo_pop_n, fifo_empty);
    end
    @(negedge clk);
    checks = checks + 1;
    if (link_valid !== 1'b0 || link_data !== 16'h0005 || flit_count !== 16'd5) begin
      failures = failures + 1;
      $display("FAIL burst_idle: valid=%0b data=%h cnt=%0d, required 0 0005 5",
               link_valid, link_data, flit_count);
    end
  endtask

  task automatic test_credit_release();
    credit_return = 1'b1;
    @(negedge clk);
    credit_return = 1'b0;
    checks = checks + 1;
    if (credits_avail !== 3'd1 || fifo_pop_n !== 1'b0 || link_valid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL release_credit: cred=%0d pop_n=%0b valid=%0b, required 1 0 0",
               credits_avail, fifo_pop_n, link_valid);
    end
    @(negedge clk);
    checks = checks + 1;
    if (link_valid !== 1'b1 || link_data !== 16'h0006 || credits_avail !== 3'd0 || flit_count !== 16'd6) begin
      failures = failures + 1;
      $display("FAIL release_launch: valid=%0b data=%h cred=%0d cnt=%0d, required 1 0006 0 6",
               link_valid, link_data, credits_avail, flit_count);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    push(16'h0a0a);
    push(16'h0b0b);
    push(16'h0c0c);
    @(negedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (credits_avail !== 3'd3 || flit_count !== 16'd2 || fifo_pop_n !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL simul_setup: cred=%0d cnt=%0d pop_n=%0b, required 3 2 0",
               credits_avail, flit_count, fifo_pop_n);
    end
    credit_return = 1'b1;
    @(negedge clk);
    credit_return = 1'b0;
    checks = checks + 1;
    if (credits_avail !== 3'd3 || flit_count !== 16'd3 || link_data !== 16'h0c0c || credit_err !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL simul_pop_return: cred=%0d cnt=%0d data=%h err=%0b, required 3 3 0c0c 0",
               credits_avail, flit_count, link_data, credit_err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    credit_return = 1'b1;
    @(negedge clk);
    credit_return = 1'b0;
    checks = checks + 1;
    if (credits_avail !== 3'd5 || credit_err !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL overflow: cred=%0d err=%0b, required 5 1", credits_avail, credit_err);
    end
    repeat (10) @(negedge clk);
    checks = checks + 1;
    if (credits_avail !== 3'd5 || credit_err !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL overflow_sticky: cred=%0d err=%0b, required 5 1", credits_avail, credit_err);
    end
  endtask

  task automatic test_enable();
    do_reset();
    push(16'h00aa);
    push(16'h00bb);
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int i = 1; i <= 4; i++) push(16'h0100 + 16'(i));
    for (int c = 0; c < 8; c++) begin
      checks = checks + 1;
      if (fifo_pop_n !== 1'b1) begin
        failures = failures + 1;
        $display("FAIL en_gate_pop_%0d: pop_n=%0b, required 1", c, fifo_pop_n);
      end
      credit_return = (c == 2 || c == 4);
      @(negedge clk);
      credit_return = 1'b0;
      checks = checks + 1;
      if (link_valid !== 1'b0) begin
        failures = failures + 1;
        $display("FAIL en_gate_valid_%0d: valid=%0b, required 0", c, link_valid);
      end
    end
    checks = checks + 1;
    if (credits_avail !== 3'd5 || credit_err !== 1'b0 || flit_count !== 16'd2) begin
      failures = failures + 1;
      $display("FAIL en_credits: cred=%0d err=%0b cnt=%0d, required 5 0 2",
               credits_avail, credit_err, flit_count);
    end
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks = checks + 1;
      if (link_valid !== 1'b1 || link_data !== 16'h0100 + 16'(i) ||
          credits_avail !== 3'(5 - i) || flit_count !== 16'(2 + i)) begin
        failures = failures + 1;
        $display("FAIL en_resume_%0d: valid=%0b data=%h cred=%0d cnt=%0d, required 1 %h %0d %0d",
                 i, link_valid, link_data, credits_avail, flit_count, 16'h0100 + 16'(i), 5 - i, 2 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 5; i++) push(16'h0200 + 16'(i));
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (credits_avail !== 3'd2 || link_valid !== 1'b1 || fifo_pop_n !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL midrst_setup: cred=%0d valid=%0b pop_n=%0b, required 2 1 0",
               credits_avail, link_valid, fifo_pop_n);
    end
    rst = 1'b1;
    #1;
    checks = checks + 1;
    if ({link_valid, link_data, credits_avail, credit_err, flit_count, fifo_pop_n} !==
        {1'b0, 16'h0000, 3'd5, 1'b0, 16'h0000, 1'b1}) begin
      failures = failures + 1;
      $display("FAIL midrst_state: valid=%0b data=%h cred=%0d err=%0b cnt=%0d pop_n=%0b, required 0 0000 5 0 0 1",
               link_valid, link_data, credits_avail, credit_err, flit_count, fifo_pop_n);
    end
    @(negedge clk);
    wr_ptr = rd_ptr;
    rst    = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    en            = 1'b0;
    credit_return = 1'b0;
    rd_ptr        = 4'd0;
    wr_ptr        = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    @(negedge clk);
    test_reset();
    test_burst();
    test_credit_release();
    test_simultaneous();
    test_overflow();
    test_enable();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flit_link_tx.md
Name: flit_link_tx

Overview:
Read-side drain controller for the router input/output buffer FIFO (single-clock, first-word-fall-through, active-low pop).
- Pops flits from the FIFO head and launches them onto a point-to-point link, one flit per cycle.
- Flow control is credit-based: a flit is launched only when the downstream buffer has a guaranteed free slot.
- Tracks downstream credits, flags protocol violations, and counts launched flits for debug.

Parameters:
- WIDTH, 16, flit width in bits (matches the FIFO WIDTH).
- CREDITS, 5, downstream buffer depth; this is the initial and maximum credit count.
- CNT_W, $clog2(CREDITS+1), credit counter width (derived; do not override).
- STAT_W, 16, launched-flit statistics counter width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  link enable; when 0, no new pops (drain pause).
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  WIDTH  FIFO head word, valid whenever fifo_empty=0.
- fifo_pop_n  out  1  active-low pop request to the FIFO (combinational).
- link_valid  out  1  registered; flit on link_data is valid this cycle.
- link_data  out  WIDTH  registered flit data.
- credit_return  in  1  one-cycle pulse; downstream freed one slot.
- credits_avail  out  CNT_W  current credit count.
- credit_err  out  1  sticky; a credit return arrived with the counter already at CREDITS.
- flit_count  out  STAT_W  number of flits launched since reset; wraps modulo 2^STAT_W.

Behaviour:
- fire = en & ~fifo_empty & (credits_avail != 0); fifo_pop_n = ~fire.
- Launch latency is 1 cycle: on the edge where fire=1, link_valid<=1 and link_data<=fifo_data. The FIFO removes its head on the same edge.
- When fire=0: link_valid<=0 and link_data holds its last value.
- Back-to-back: with credits available and a non-empty FIFO, one flit launches per cycle. link_valid stays high continuously.
- Credit update each edge: next = credits_avail - fire + credit_return.
  - fire and credit_return in the same cycle: count unchanged.
  - credits_avail=0: fire is 0. A credit_return in that cycle raises the count to 1, and a pop may occur on the next cycle.
  - credit_return while the count is at CREDITS and fire=0: the count stays at CREDITS (saturates) and credit_err<=1. credit_err stays set until rst.
- flit_count increments by 1 on every edge with fire=1 and wraps from 2^STAT_W-1 to 0.
- en deassertion blocks only new pops. A flit already in link_valid still completes its cycle, and credit returns are still accepted.
- No state machine beyond the counters. The design is purely credit-gated; the link has no ready signal.
- Reset values, forced asynchronously on rst=1:
  - link_valid=0, link_data=0
  - credits_avail=CREDITS
  - credit_err=0
  - flit_count=0
- fifo_pop_n=1 throughout reset. It is a combinational output, so an explicit rst term in fire is required.
- Reset mid-operation: an in-flight flit is dropped and credits are restored to CREDITS. The downstream is reset in the same domain.
- Never pop when fifo_empty=1. Popping an empty FIFO is a design bug; the bench asserts against it.

Decomposition:
- Shared package (knock_pkg): FLIT_W default; CREDITS default; credit counter typedef credit_t sized by $clog2(CREDITS+1); flit_t typedef logic [FLIT_W-1:0].
- One natural sub-module, credit_counter: up/down saturating counter with the err flag. The router output port and the future link receiver reuse it.
- The flit_count statistics counter stays inline.

Test Plan:
- Reset: assert rst mid-stream with credits_avail=2 and link_valid=1 → immediately link_valid=0, credits_avail=5, credit_err=0, flit_count=0, fifo_pop_n=1.
- Burst: FIFO preloaded with 0x0001..0x0005, no credit returns → five consecutive link_valid cycles carrying 0x0001..0x0005 in order, starting 1 cycle after the first pop. credits_avail then 0, fifo_pop_n=1 while the FIFO still holds data (push 0x0006 first).
- Credit starvation release: credits_avail=0, FIFO holding 0x0006, pulse credit_return → next cycle credits_avail=1 and pop. Following cycle link_valid=1, link_data=0x0006, credits_avail=0.
- Simultaneous pop and return: credits_avail=3, fire and credit_return in the same cycle → credits_avail stays 3, flit_count +1.
- Overflow error: credits_avail=5, FIFO empty, pulse credit_return → credits_avail=5, credit_err=1. It remains 1 after 10 further idle cycles.
- Enable gating: en=0 with 4 flits queued → fifo_pop_n=1 and link_valid=0 for 8 cycles, credit returns still counted. Then en=1 → 4 consecutive flits launched.
